// File: rtl/fft_pkg.sv
// fft_pkg: shared types and defaults for the FFT frame sequencer.
// Holds the FSM state enum, parameter defaults and the bit-reverse helper.
package fft_pkg;

  localparam int NPTS_DEF = 64;
  localparam int DW_DEF   = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_RUN,
    ST_DRAIN
  } fsm_e;

  // Reverse the low w bits of v; bits at and above w come back zero.
  function automatic logic [15:0] bitrev(
    input logic [15:0] v,
    input int unsigned w
  );
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      if (b < int'(w)) begin
        r[int'(w) - 1 - b] = v[b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_buf.sv
// fft_stage_buf: staging array for one input frame.
// Entries are written one at a time and cleared together.
module fft_stage_buf
  import fft_pkg::*;
#(
  parameter int NPTS = NPTS_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = $clog2(NPTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_idx_i,
  input  logic [DW-1:0]            wr_re_i,
  input  logic [DW-1:0]            wr_im_i,
  output logic [NPTS-1:0][DW-1:0]  buf_re_o,
  output logic [NPTS-1:0][DW-1:0]  buf_im_o
);

  logic [NPTS-1:0][DW-1:0] re_q;
  logic [NPTS-1:0][DW-1:0] im_q;

  // Clear wins over write so a new frame always starts from zeros.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      re_q <= '0;
      im_q <= '0;
    end else if (wr_en_i) begin
      re_q[wr_idx_i] <= wr_re_i;
      im_q[wr_idx_i] <= wr_im_i;
    end
  end

  assign buf_re_o = re_q;
  assign buf_im_o = im_q;

endmodule

// File: rtl/fft_frame_seq.sv
// fft_frame_seq: loads a frame, commits it to the bank, runs the engine, drains.
// Define FFT_BITREV_OUT_EN to drain the bank in bit-reversed index order.
module fft_frame_seq
  import fft_pkg::*;
#(
  parameter int NPTS = NPTS_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_last,
  input  logic [DW-1:0]            s_re,
  input  logic [DW-1:0]            s_im,
  output logic [NPTS-1:0][DW-1:0]  bank_dr,
  output logic [NPTS-1:0][DW-1:0]  bank_di,
  output logic                     bank_wren,
  input  logic [NPTS-1:0][DW-1:0]  bank_qr,
  input  logic [NPTS-1:0][DW-1:0]  bank_qi,
  output logic                     fft_start,
  input  logic                     fft_done,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [DW-1:0]            m_re,
  output logic [DW-1:0]            m_im,
  output logic                     busy
);

  localparam int AW = $clog2(NPTS);
  localparam logic [AW-1:0] IDX_MAX = AW'(NPTS - 1);

  fsm_e          state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] oidx_q, oidx_d;
  logic          first_q, first_d;
  logic [AW-1:0] ridx;

  logic s_fire;
  logic m_fire;
  logic load_end;
  logic drain_end;

  assign s_fire    = s_valid && (state_q == ST_LOAD);
  assign m_fire    = m_ready && (state_q == ST_DRAIN);
  assign load_end  = s_fire && ((idx_q == IDX_MAX) || s_last);
  assign drain_end = m_fire && (oidx_q == IDX_MAX);

`ifdef FFT_BITREV_OUT_EN
  assign ridx = AW'(bitrev(16'(oidx_q), AW));
`else
  assign ridx = oidx_q;
`endif

  fft_stage_buf #(
    .NPTS (NPTS),
    .DW   (DW),
    .AW   (AW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (drain_end),
    .wr_en_i  (s_fire),
    .wr_idx_i (idx_q),
    .wr_re_i  (s_re),
    .wr_im_i  (s_im),
    .buf_re_o (bank_dr),
    .buf_im_o (bank_di)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fft_done is only honoured after the start pulse cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = ST_LOAD;
      ST_LOAD:   if (load_end) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_RUN;
      ST_RUN:    if (!first_q && fft_done) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_end) state_d = ST_LOAD;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state and drain index.
  always_comb begin
    s_ready   = 1'b0;
    bank_wren = 1'b0;
    fft_start = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_re      = '0;
    m_im      = '0;
    busy      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE:   ;
      ST_LOAD:   s_ready = 1'b1;
      ST_COMMIT: bank_wren = 1'b1;
      ST_RUN:    fft_start = first_q;
      ST_DRAIN: begin
        m_valid = 1'b1;
        m_last  = (oidx_q == IDX_MAX);
        m_re    = bank_qr[ridx];
        m_im    = bank_qi[ridx];
      end
      default:   ;
    endcase
  end

  // Next values for the load/drain indices and the start-pulse flag.
  always_comb begin
    idx_d   = idx_q;
    oidx_d  = oidx_q;
    first_d = (state_q == ST_COMMIT);
    if (s_fire) begin
      idx_d = idx_q + AW'(1);
    end
    if (load_end || drain_end) begin
      idx_d = '0;
    end
    if (m_fire) begin
      oidx_d = oidx_q + AW'(1);
    end
  end

  // Index and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      oidx_q  <= '0;
      first_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
      first_q <= first_d;
    end
  end

endmodule

// File: doc/fft_frame_seq.md
FFT_FRAME_SEQ -- requirements
Module: fft_frame_seq

Interface
REQ-001 SHALL have parameter NPTS, default 64, points per frame (power of two).
REQ-002 SHALL have parameter DW, default 32, width of each real/imag word.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1; reset is synchronous, active-high.
REQ-005 SHALL have ports s_valid/s_ready/s_last, input/output/input, 1 each; sample-in handshake.
REQ-006 SHALL have ports s_re, s_im, input, DW each; input sample.
REQ-007 SHALL have ports bank_dr, bank_di, output, DW x NPTS each; frame image driven to coefficient bank.
REQ-008 SHALL have port bank_wren, output, 1; bank write strobe.
REQ-009 SHALL have ports bank_qr, bank_qi, input, DW x NPTS each; bank contents after transform.
REQ-010 SHALL have ports fft_start/fft_done, output/input, 1 each; transform engine handshake.
REQ-011 SHALL have ports m_valid/m_ready/m_last, output/input/output, 1 each; result-out handshake.
REQ-012 SHALL have ports m_re, m_im, output, DW each; result sample.
REQ-013 SHALL have port busy, output, 1; high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, LOAD, COMMIT, RUN, DRAIN.
REQ-015 IDLE SHALL move to LOAD on the cycle after reset deasserts; LOAD is the only state with s_ready=1.
REQ-016 LOAD: each cycle with s_valid&s_ready SHALL write s_re/s_im into staging entry idx and increment idx (log2 NPTS bits).
REQ-017 LOAD SHALL exit to COMMIT after the transfer at idx=NPTS-1, or after a transfer with s_last=1, whichever comes first.
REQ-018 Early s_last: entries above the last written index SHALL be zero in bank_dr/bank_di.
REQ-019 Transfers after the NPTS-th are not accepted (s_ready=0); s_last is ignored at idx=NPTS-1 (same exit).
REQ-020 COMMIT SHALL hold bank_wren=1 for exactly one cycle with staging on bank_dr/bank_di, then go to RUN.
REQ-021 RUN SHALL pulse fft_start for exactly one cycle (first RUN cycle), then wait for fft_done=1 (sampled, level or pulse), then go to DRAIN.
REQ-022 fft_done asserted coincident with fft_start SHALL be ignored.
REQ-023 DRAIN SHALL present bank_qr/qi entry at output index oidx on m_re/m_im with m_valid=1; oidx advances only on m_valid&m_ready.
REQ-024 m_last SHALL be 1 exactly when oidx=NPTS-1; on that transfer the block SHALL return to LOAD with idx=0 and staging cleared.
REQ-025 m_re/m_im/m_last SHALL be stable while m_valid=1 and m_ready=0.
REQ-026 Latency: final input transfer to first m_valid = 3 cycles + engine time (COMMIT, fft_start cycle, fft_done sample cycle).

Reset
REQ-027 Reset SHALL override all activity in any state: state=IDLE, idx=oidx=0, staging zeroed.
REQ-028 Reset values: s_ready=0, bank_wren=0, fft_start=0, m_valid=0, m_last=0, m_re=m_im=0, busy=0, bank_dr/bank_di all zero.

Configuration
REQ-029 Macro FFT_BITREV_OUT_EN defined: DRAIN SHALL read bank entry bitreverse(oidx) (log2 NPTS bits); m_last still tied to oidx=NPTS-1.
REQ-030 Macro undefined: DRAIN SHALL read bank entry oidx directly; no reorder logic present.

Structure
REQ-031 Shared package fft_pkg SHALL hold the state enum type, NPTS/DW defaults, and a bitrev function.
REQ-032 Staging array plus write/clear logic SHALL be a sub-module fft_stage_buf; FSM and output mux stay in fft_frame_seq.

Verification
REQ-033 Full frame: 64 samples re=i, im=-i, m_ready=1, engine echoes bank -> one bank_wren pulse, one fft_start pulse, outputs re=0..63 in order, m_last on 63.
REQ-034 Early s_last at sample 9 (idx 9) -> bank_dr[10..63]=0, COMMIT next cycle, 64 outputs drained.
REQ-035 Backpressure: m_ready toggles 1/0 each cycle -> no lost or duplicated outputs, data stable while stalled, drain takes 127 cycles.
REQ-036 Reset asserted in RUN after fft_start -> next cycle busy=0, all outputs zero; late fft_done ignored; new frame loads normally.
REQ-037 FFT_BITREV_OUT_EN defined, bank_qr[k]=k -> output sequence 0,32,16,48,8,...,63.
REQ-038 s_valid held high through 70 samples without s_last -> exactly 64 accepted, s_ready=0 from COMMIT until DRAIN completes.
